t_minute_hour: RTL
==================

# t_minute_hour

Minute/hour timekeeping stage of the digital clock. Consumes the level-type carry that the seconds stage raises on each 59→00 wrap. Advances a minute field 0–59 and an hour field 0–23, and emits a one-cycle day carry. Supports push-button adjustment of either field and drives four 7-segment digits (hour tens/units, minute tens/units) for the display board.

## Interface
- No parameters; field limits fixed at 60 minutes and 24 hours.
- clk50 — in — 1 — system clock, 50 MHz; all state on rising edge.
- reset — in — 1 — asynchronous, active-low; clears all state immediately.
- sec_carry — in — 1 — seconds-stage carry, level signal; high for one or more cycles per seconds wrap.
- disable_clk — in — 1 — 1 = timekeeping paused; carry edges ignored and not queued.
- control1 — in — 1 — adjust button, active-low press.
- control0 — in — 1 — adjust direction: 1 = up, 0 = down.
- sel — in — 1 — adjust target: 0 = minutes, 1 = hours.
- minute — out — 6 — current minute, binary 0–59, registered.
- hour — out — 5 — current hour, binary 0–23, registered.
- equal24 — out — 1 — one-cycle pulse on the 23:59→00:00 rollover, registered.
- led_m1, led_m2 — out — 7 each — segments for minute units and minute tens.
- led_h1, led_h2 — out — 7 each — segments for hour units and hour tens.

## Operation
- Carry detect:
  - carry_q is the registered sec_carry.
  - An edge is sec_carry & ~carry_q. One edge equals one minute step, regardless of how long sec_carry stays high.
- Button arming:
  - armed = 1 after reset.
  - control1 = 0 with armed = 1 produces one adjust step and clears armed.
  - control1 = 1 sets armed. Holding the button gives exactly one step.
- Adjust step, applied to the field selected by sel:
  - Up wraps 59→0 (minutes) or 23→0 (hours).
  - Down wraps 0→59 or 0→23.
  - No ripple into the other field. Adjust never asserts equal24.
  - Adjust works regardless of disable_clk.
- Carry step:
  - Minute below 59: minute + 1.
  - Minute = 59: minute → 0 and hour + 1.
  - 23:59: both fields → 0 and equal24 = 1 for that one cycle.
- Priority: adjust step > carry step.
  - If both occur in the same cycle, apply the adjust.
  - Set pending = 1; the carry step is applied on the next cycle where no adjust occurs.
  - Only one carry is queued; a second edge while pending is set is dropped.
- disable_clk = 1:
  - Carry edges are discarded.
  - pending is cleared without being applied.
  - carry_q keeps tracking sec_carry.
- Display:
  - Split each field into tens and units (value/10, value%10).
  - Segment order {g,f,e,d,c,b,a}, active-low.
  - Codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Segments are combinational from the registered fields.

## Timing
- Reset values:
  - minute = 0, hour = 0, equal24 = 0, armed = 1, pending = 0.
  - carry_q = 1, so sec_carry held high across reset release is not counted.
  - All led_* outputs = 1000000.
- Carry latency: sec_carry sampled high at edge N (with carry_q = 0) → minute/hour updated at edge N; visible after edge N.
- Deferred carry: applied at edge N+1 or the first later non-adjust edge.
- Adjust latency: control1 sampled low at edge N → field updated after edge N.
- equal24 is high for exactly the one cycle following the rollover edge, then low.
- Reset mid-operation:
  - Outputs clear asynchronously; a pending carry is lost.
  - The first carry edge after release requires sec_carry to go low, then high.
- Field values never leave range; illegal states are unreachable from reset.

## Test plan
- Reset, then three sec_carry pulses of 1, 5 and 60 cycles (low gaps between) → minute = 3, hour = 0; led_m1 = 0110000, led_m2 = 1000000.
- Preload 23:59 via adjust (sel = 1 down once, sel = 0 down once), then one carry edge → minute = 0, hour = 0, equal24 high exactly one cycle.
- Hold control1 low 100 cycles with control0 = 1, sel = 0 from 00:00 → minute = 1. Release, press again with control0 = 0 → minute = 0. Press once more → minute = 59, hour unchanged at 0.
- Press in the same cycle as a carry edge at 00:10, sel = 0, up → 00:11 after that edge, 00:12 one cycle later. A second edge during pending → still 00:12.
- disable_clk = 1, four carry edges → time unchanged. Drop disable_clk while sec_carry is high → no step until the next rising edge.
- sec_carry held high, pulse reset low mid-run at 00:37 → 00:00 immediately, all led_* = 1000000. No step after release until sec_carry toggles low→high.

Source files
------------

// File: rtl/t_minute_hour.sv
// Minute/hour timekeeping stage: counts seconds-stage carries, supports button
// adjustment of either field, and drives four active-low 7-segment digits.
module t_minute_hour (
    input  logic       clk50,
    input  logic       reset,
    input  logic       sec_carry,
    input  logic       disable_clk,
    input  logic       control1,
    input  logic       control0,
    input  logic       sel,
    output logic [5:0] minute,
    output logic [4:0] hour,
    output logic       equal24,
    output logic [6:0] led_m1,
    output logic [6:0] led_m2,
    output logic [6:0] led_h1,
    output logic [6:0] led_h2
);

    logic [5:0] r_minute;
    logic [4:0] r_hour;
    logic       r_equal24;
    logic       r_carry_q;
    logic       r_armed;
    logic       r_pending;

    logic       w_edge;
    logic       w_adj;
    logic       w_carry;
    logic [7:0] w_m_bcd;
    logic [7:0] w_h_bcd;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one decimal digit
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Split a 0..59 value into {tens, units} without a divider
    function automatic logic [7:0] bcd_split(input logic [5:0] v);
        logic [3:0] t;
        logic [5:0] base;
        if (v >= 6'd50) begin
            t = 4'd5; base = 6'd50;
        end else if (v >= 6'd40) begin
            t = 4'd4; base = 6'd40;
        end else if (v >= 6'd30) begin
            t = 4'd3; base = 6'd30;
        end else if (v >= 6'd20) begin
            t = 4'd2; base = 6'd20;
        end else if (v >= 6'd10) begin
            t = 4'd1; base = 6'd10;
        end else begin
            t = 4'd0; base = 6'd0;
        end
        bcd_split = {t, 4'(v - base)};
    endfunction

    assign w_edge  = sec_carry & ~r_carry_q;
    assign w_adj   = ~control1 & r_armed;
    // A queued carry is serviced on the first cycle without an adjust
    assign w_carry = ~disable_clk & (w_edge | r_pending);

    // Field state, carry/button edge tracking and rollover pulse
    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            r_minute  <= 6'd0;
            r_hour    <= 5'd0;
            r_equal24 <= 1'b0;
            r_carry_q <= 1'b1;
            r_armed   <= 1'b1;
            r_pending <= 1'b0;
        end else begin
            r_carry_q <= sec_carry;
            r_armed   <= control1;
            r_equal24 <= 1'b0;

            if (w_adj) begin
                if (sel) begin
                    if (control0) r_hour <= (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
                    else          r_hour <= (r_hour == 5'd0) ? 5'd23 : r_hour - 5'd1;
                end else begin
                    if (control0) r_minute <= (r_minute == 6'd59) ? 6'd0 : r_minute + 6'd1;
                    else          r_minute <= (r_minute == 6'd0) ? 6'd59 : r_minute - 6'd1;
                end
            end else if (w_carry) begin
                if (r_minute == 6'd59) begin
                    r_minute <= 6'd0;
                    if (r_hour == 5'd23) begin
                        r_hour    <= 5'd0;
                        r_equal24 <= 1'b1;
                    end else begin
                        r_hour <= r_hour + 5'd1;
                    end
                end else begin
                    r_minute <= r_minute + 6'd1;
                end
            end else begin
                r_minute <= r_minute;
            end

            if (disable_clk)  r_pending <= 1'b0;
            else if (w_adj)   r_pending <= r_pending | w_edge;
            else              r_pending <= 1'b0;
        end
    end

    assign minute  = r_minute;
    assign hour    = r_hour;
    assign equal24 = r_equal24;

    // Display decode straight from the registered fields
    always_comb begin
        w_m_bcd = bcd_split(r_minute);
        w_h_bcd = bcd_split({1'b0, r_hour});
        led_m1  = seg7(w_m_bcd[3:0]);
        led_m2  = seg7(w_m_bcd[7:4]);
        led_h1  = seg7(w_h_bcd[3:0]);
        led_h2  = seg7(w_h_bcd[7:4]);
    end

endmodule
